// File: rtl/branch_pkg.sv
// Shared definitions for the branch/PC unit: condition encodings and default widths.
package branch_pkg;
    localparam int PC_W_DEF  = 8;
    localparam int OFS_W_DEF = 5;

    typedef enum logic [1:0] {
        COND_Z  = 2'b00,
        COND_N  = 2'b01,
        COND_NZ = 2'b10,
        COND_NN = 2'b11
    } cond_e;
endpackage

// File: rtl/branch_cond.sv
// Combinational condition evaluator for conditional branches.
module branch_cond
    import branch_pkg::*;
(
    input  logic [1:0] cond,
    input  logic       z,
    input  logic       n,
    output logic       cond_true
);
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_Z:  cond_true = z;
            COND_N:  cond_true = n;
            COND_NZ: cond_true = ~z;
            COND_NN: cond_true = ~n;
            default: cond_true = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_pc_unit.sv
// Program counter with relative/absolute branches, link register and Z/N flags.
module branch_pc_unit
    import branch_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int OFS_W = OFS_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flag_we,
    input  logic             z_in,
    input  logic             n_in,
    input  logic             branch,
    input  logic             branch_if,
    input  logic [1:0]       cond,
    input  logic             brx,
    input  logic             link,
    input  logic [OFS_W-1:0] offset,
    input  logic [PC_W-1:0]  target,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  link_reg,
    output logic             taken,
    output logic             z,
    output logic             n
);
    logic            cond_true;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] ofs_ext;
    logic [PC_W-1:0] rel_pc;
    logic [PC_W-1:0] nxt_pc;
    logic            nxt_tk;

    // Condition sees only the registered flags, so a same-cycle flag_we cannot steer it.
    branch_cond u_cond (
        .cond      (cond),
        .z         (z),
        .n         (n),
        .cond_true (cond_true)
    );

    assign pc_inc  = pc + PC_W'(1);
    assign ofs_ext = PC_W'($signed(offset));
    assign rel_pc  = pc_inc + ofs_ext;

    always_comb begin
        nxt_pc = pc_inc;
        nxt_tk = 1'b0;
        if (brx) begin
            nxt_pc = target;
            nxt_tk = 1'b1;
        end else if (branch || (branch_if && cond_true)) begin
            nxt_pc = rel_pc;
            nxt_tk = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= '0;
            link_reg <= '0;
            taken    <= 1'b0;
            z        <= 1'b0;
            n        <= 1'b0;
        end else if (stall) begin
            taken    <= 1'b0;
        end else begin
            pc       <= nxt_pc;
            taken    <= nxt_tk;
            if (nxt_tk && link)
                link_reg <= pc_inc;
            if (flag_we) begin
                z <= z_in;
                n <= n_in;
            end
        end
    end
endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit at PC_W=8, OFS_W=5.
module tb_branch_pc_unit;
    logic       clk = 1'b0;
    logic       rst, stall, flag_we, z_in, n_in, branch, branch_if, brx, link;
    logic [1:0] cond;
    logic [4:0] offset;
    logic [7:0] target;
    logic [7:0] pc, link_reg;
    logic       taken, z, n;

    int total  = 0;
    int passed = 0;

    typedef struct packed {
        logic       rst, stall, fwe, zi, ni, br, bif;
        logic [1:0] cond;
        logic       brx, link;
        logic [4:0] ofs;
        logic [7:0] tgt;
    } stim_t;

    typedef struct packed {
        logic [7:0] pc, lr;
        logic       tk, z, n;
    } obs_t;

    obs_t exp_q[$];

    branch_pc_unit #(.PC_W(8), .OFS_W(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flag_we(flag_we), .z_in(z_in), .n_in(n_in),
        .branch(branch), .branch_if(branch_if), .cond(cond), .brx(brx), .link(link),
        .offset(offset), .target(target), .pc(pc), .link_reg(link_reg), .taken(taken),
        .z(z), .n(n)
    );

    always #5 clk = ~clk;

    task automatic drive(input stim_t s);
        rst = s.rst; stall = s.stall; flag_we = s.fwe; z_in = s.zi; n_in = s.ni;
        branch = s.br; branch_if = s.bif; cond = s.cond; brx = s.brx; link = s.link;
        offset = s.ofs; target = s.tgt;
    endtask

    localparam stim_t IDLE = '0;

    task automatic test_reset();
        stim_t s[4]; obs_t x[4]; obs_t o, e;
        s[0] = IDLE; s[0].rst = 1'b1;        x[0] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        s[1] = IDLE;                         x[1] = '{8'h01, 8'h00, 1'b0, 1'b0, 1'b0};
        s[2] = IDLE;                         x[2] = '{8'h02, 8'h00, 1'b0, 1'b0, 1'b0};
        s[3] = IDLE;                         x[3] = '{8'h03, 8'h00, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(s[i]); exp_q.push_back(x[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = '{pc, link_reg, taken, z, n}; total++;
            if (o !== e) $display("FAIL reset[%0d]: got pc=%h lr=%h tk=%b z=%b n=%b want pc=%h lr=%h tk=%b z=%b n=%b",
                                  i, o.pc, o.lr, o.tk, o.z, o.n, e.pc, e.lr, e.tk, e.z, e.n);
            else passed++;
        end
    endtask

    task automatic test_relative();
        stim_t s[8]; obs_t x[8]; obs_t o, e;
        s[0] = IDLE; s[0].brx = 1; s[0].tgt = 8'h10;  x[0] = '{8'h10, 8'h00, 1'b1, 1'b0, 1'b0};
        s[1] = IDLE; s[1].br = 1; s[1].ofs = 5'b11101; x[1] = '{8'h0E, 8'h00, 1'b1, 1'b0, 1'b0};
        s[2] = IDLE;                                  x[2] = '{8'h0F, 8'h00, 1'b0, 1'b0, 1'b0};
        s[3] = IDLE; s[3].brx = 1; s[3].tgt = 8'hFF;  x[3] = '{8'hFF, 8'h00, 1'b1, 1'b0, 1'b0};
        s[4] = IDLE;                                  x[4] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        s[5] = IDLE; s[5].br = 1; s[5].ofs = 5'b11100; x[5] = '{8'hFD, 8'h00, 1'b1, 1'b0, 1'b0};
        s[6] = IDLE; s[6].brx = 1; s[6].tgt = 8'hFE;  x[6] = '{8'hFE, 8'h00, 1'b1, 1'b0, 1'b0};
        s[7] = IDLE; s[7].br = 1; s[7].ofs = 5'b01111; x[7] = '{8'h0E, 8'h00, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            drive(s[i]); exp_q.push_back(x[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = '{pc, link_reg, taken, z, n}; total++;
            if (o !== e) $display("FAIL relative[%0d]: got pc=%h lr=%h tk=%b z=%b n=%b want pc=%h lr=%h tk=%b z=%b n=%b",
                                  i, o.pc, o.lr, o.tk, o.z, o.n, e.pc, e.lr, e.tk, e.z, e.n);
            else passed++;
        end
    endtask

    task automatic test_cond();
        stim_t s[9]; obs_t x[9]; obs_t o, e;
        s[0] = IDLE; s[0].brx = 1; s[0].tgt = 8'h20; s[0].fwe = 1; s[0].zi = 1;
        x[0] = '{8'h20, 8'h00, 1'b1, 1'b1, 1'b0};
        s[1] = IDLE; s[1].bif = 1; s[1].cond = 2'b00; s[1].ofs = 5'd4;
        x[1] = '{8'h25, 8'h00, 1'b1, 1'b1, 1'b0};
        s[2] = IDLE; s[2].brx = 1; s[2].tgt = 8'h20;
        x[2] = '{8'h20, 8'h00, 1'b1, 1'b1, 1'b0};
        s[3] = IDLE; s[3].bif = 1; s[3].cond = 2'b10; s[3].ofs = 5'd4;
        x[3] = '{8'h21, 8'h00, 1'b0, 1'b1, 1'b0};
        s[4] = IDLE; s[4].bif = 1; s[4].cond = 2'b00; s[4].ofs = 5'd4; s[4].fwe = 1; s[4].zi = 0;
        x[4] = '{8'h26, 8'h00, 1'b1, 1'b0, 1'b0};
        s[5] = IDLE; s[5].bif = 1; s[5].cond = 2'b00; s[5].ofs = 5'd4;
        x[5] = '{8'h27, 8'h00, 1'b0, 1'b0, 1'b0};
        s[6] = IDLE; s[6].fwe = 1; s[6].ni = 1;
        x[6] = '{8'h28, 8'h00, 1'b0, 1'b0, 1'b1};
        s[7] = IDLE; s[7].bif = 1; s[7].cond = 2'b01; s[7].ofs = 5'd2;
        x[7] = '{8'h2B, 8'h00, 1'b1, 1'b0, 1'b1};
        s[8] = IDLE; s[8].bif = 1; s[8].cond = 2'b11; s[8].ofs = 5'd2;
        x[8] = '{8'h2C, 8'h00, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            drive(s[i]); exp_q.push_back(x[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = '{pc, link_reg, taken, z, n}; total++;
            if (o !== e) $display("FAIL cond[%0d]: got pc=%h lr=%h tk=%b z=%b n=%b want pc=%h lr=%h tk=%b z=%b n=%b",
                                  i, o.pc, o.lr, o.tk, o.z, o.n, e.pc, e.lr, e.tk, e.z, e.n);
            else passed++;
        end
    endtask

    task automatic test_link_priority();
        stim_t s[6]; obs_t x[6]; obs_t o, e;
        s[0] = IDLE; s[0].brx = 1; s[0].tgt = 8'h40;
        x[0] = '{8'h40, 8'h00, 1'b1, 1'b0, 1'b1};
        s[1] = IDLE; s[1].brx = 1; s[1].br = 1; s[1].tgt = 8'h80; s[1].link = 1; s[1].ofs = 5'd5;
        x[1] = '{8'h80, 8'h41, 1'b1, 1'b0, 1'b1};
        s[2] = IDLE; s[2].bif = 1; s[2].cond = 2'b11; s[2].link = 1; s[2].ofs = 5'd2;
        x[2] = '{8'h81, 8'h41, 1'b0, 1'b0, 1'b1};
        s[3] = IDLE; s[3].link = 1;
        x[3] = '{8'h82, 8'h41, 1'b0, 1'b0, 1'b1};
        s[4] = IDLE; s[4].br = 1; s[4].link = 1; s[4].ofs = 5'd2;
        x[4] = '{8'h85, 8'h83, 1'b1, 1'b0, 1'b1};
        s[5] = IDLE; s[5].br = 1; s[5].bif = 1; s[5].cond = 2'b01; s[5].ofs = 5'd1;
        x[5] = '{8'h87, 8'h83, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(s[i]); exp_q.push_back(x[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = '{pc, link_reg, taken, z, n}; total++;
            if (o !== e) $display("FAIL link_prio[%0d]: got pc=%h lr=%h tk=%b z=%b n=%b want pc=%h lr=%h tk=%b z=%b n=%b",
                                  i, o.pc, o.lr, o.tk, o.z, o.n, e.pc, e.lr, e.tk, e.z, e.n);
            else passed++;
        end
    endtask

    task automatic test_stall();
        stim_t s[4]; obs_t x[4]; obs_t o, e;
        s[0] = IDLE; s[0].brx = 1; s[0].tgt = 8'h30;
        x[0] = '{8'h30, 8'h83, 1'b1, 1'b0, 1'b1};
        s[1] = IDLE; s[1].stall = 1; s[1].brx = 1; s[1].tgt = 8'h55; s[1].fwe = 1; s[1].zi = 1; s[1].link = 1;
        x[1] = '{8'h30, 8'h83, 1'b0, 1'b0, 1'b1};
        s[2] = IDLE; s[2].stall = 1; s[2].br = 1; s[2].ofs = 5'd3;
        x[2] = '{8'h30, 8'h83, 1'b0, 1'b0, 1'b1};
        s[3] = IDLE;
        x[3] = '{8'h31, 8'h83, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(s[i]); exp_q.push_back(x[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = '{pc, link_reg, taken, z, n}; total++;
            if (o !== e) $display("FAIL stall[%0d]: got pc=%h lr=%h tk=%b z=%b n=%b want pc=%h lr=%h tk=%b z=%b n=%b",
                                  i, o.pc, o.lr, o.tk, o.z, o.n, e.pc, e.lr, e.tk, e.z, e.n);
            else passed++;
        end
    endtask

    task automatic test_reset_override();
        stim_t s[3]; obs_t x[3]; obs_t o, e;
        s[0] = IDLE; s[0].brx = 1; s[0].tgt = 8'h30;
        x[0] = '{8'h30, 8'h83, 1'b1, 1'b0, 1'b1};
        s[1] = IDLE; s[1].rst = 1; s[1].stall = 1; s[1].brx = 1; s[1].tgt = 8'h30;
        s[1].link = 1; s[1].fwe = 1; s[1].zi = 1; s[1].ni = 1;
        x[1] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        s[2] = IDLE;
        x[2] = '{8'h01, 8'h00, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(s[i]); exp_q.push_back(x[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front(); o = '{pc, link_reg, taken, z, n}; total++;
            if (o !== e) $display("FAIL rst_override[%0d]: got pc=%h lr=%h tk=%b z=%b n=%b want pc=%h lr=%h tk=%b z=%b n=%b",
                                  i, o.pc, o.lr, o.tk, o.z, o.n, e.pc, e.lr, e.tk, e.z, e.n);
            else passed++;
        end
    endtask

    initial begin
        drive(IDLE);
        rst = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_relative();
        test_cond();
        test_link_priority();
        test_stall();
        test_reset_override();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
